tree_loader: RTL and testbench

TREE_LOADER -- requirements
Module: tree_loader

---
 rtl/tree_loader_pkg.sv | 22 ++
 rtl/tree_rec_assembler.sv | 54 +++++
 rtl/tree_loader.sv | 196 +++++++++++++++++++
 tb/tb_tree_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_loader_pkg.sv
// Shared constants and state encoding for the tree image loader.
package tree_loader_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         RECORD_BYTES = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_START,
    ST_ERR
  } state_e;

  // States in which the loader takes bytes from the stream.
  function automatic logic state_accepts(input state_e s);
    return (s != ST_WRITE) && (s != ST_START);
  endfunction

endpackage

// File: rtl/tree_rec_assembler.sv
// Node record assembler: shifts stream bytes MSB-first into a record
// register and keeps the running XOR checksum of every shifted byte.
// Only the last RAM1+RAM2 bits of a record are kept, so the unused top
// bits of the first coefficient byte fall off the end naturally.
module tree_rec_assembler
  import tree_loader_pkg::*;
#(
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       shift_i,
  input  logic [7:0]                 byte_i,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data_o,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data_o,
  output logic [7:0]                 chk_o
);

  localparam int REC_W = RAM1_DATA_WIDTH + RAM2_DATA_WIDTH;

  logic [REC_W-1:0] rec_q, rec_d;
  logic [7:0]       chk_q, chk_d;

  // Next record/checksum: clear starts a frame, shift absorbs one byte.
  always_comb begin
    rec_d = rec_q;
    chk_d = chk_q;
    if (clr_i) begin
      chk_d = 8'h00;
    end
    if (shift_i) begin
      rec_d = {rec_q[REC_W-9:0], byte_i};
      chk_d = chk_d ^ byte_i;
    end
  end

  // Record and checksum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
      chk_q <= 8'h00;
    end else begin
      rec_q <= rec_d;
      chk_q <= chk_d;
    end
  end

  assign ram1_data_o = rec_q[RAM2_DATA_WIDTH +: RAM1_DATA_WIDTH];
  assign ram2_data_o = rec_q[RAM2_DATA_WIDTH-1:0];
  assign chk_o       = chk_q;

endmodule

// File: rtl/tree_loader.sv
// Tree image loader: parses SYNC/COUNT/records/CHK frames, writes each
// node record into the coefficient and child memories with a held write
// strobe, then strobes the traversal engine's root-address load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | hunting for SYNC, other bytes dropped
// COUNT    | next byte is node count N, range checked
// RECV     | collecting the 7 bytes of one node record
// WRITE    | we1/we2 held for WR_HOLD cycles at node index
// CHECK    | next byte is compared against the running XOR
// START    | start held for WR_HOLD cycles at addr 0, then done pulse
// ERR      | sticky error, waiting for SYNC to resynchronise
module tree_loader
  import tree_loader_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 16,
  parameter int WR_HOLD         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       we1,
  output logic                       we2,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
  output logic                       start,
  output logic                       done,
  output logic                       err
);

  localparam int IDXW      = ADDR_WIDTH + 1;
  localparam int MAX_NODES = 2 ** ADDR_WIDTH;
  localparam int HOLDW     = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HOLDW-1:0] HOLD_LOAD = HOLDW'(WR_HOLD - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(RECORD_BYTES - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d, cnt_q, cnt_d, idx_inc;
  logic [2:0]        byte_q, byte_d;
  logic [HOLDW-1:0]  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              take, chk_clr, rec_shift;
  logic [7:0]        chk;

  // in_ready is registered, so a transfer is simply valid while ready.
  assign take    = in_valid & rdy_q;
  assign idx_inc = idx_q + 1'b1;

  tree_rec_assembler #(
    .RAM1_DATA_WIDTH(RAM1_DATA_WIDTH),
    .RAM2_DATA_WIDTH(RAM2_DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (chk_clr),
    .shift_i    (rec_shift),
    .byte_i     (in_data),
    .ram1_data_o(ram1_data),
    .ram2_data_o(ram2_data),
    .chk_o      (chk)
  );

  // Next-state and next-output decode; strobes default low every cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    hold_d    = hold_q;
    addr_d    = '0;
    we_d      = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    chk_clr   = 1'b0;
    rec_shift = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (take && in_data == SYNC_BYTE) begin
          err_d   = 1'b0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (take) begin
          if (in_data != 8'd0 && int'(in_data) <= MAX_NODES) begin
            cnt_d   = IDXW'(in_data);
            idx_d   = '0;
            byte_d  = 3'd0;
            chk_clr = 1'b1;
            state_d = ST_RECV;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_RECV: begin
        if (take) begin
          rec_shift = 1'b1;
          if (byte_q == LAST_BYTE) begin
            byte_d  = 3'd0;
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            hold_d  = HOLD_LOAD;
            state_d = ST_WRITE;
          end else begin
            byte_d = byte_q + 3'd1;
          end
        end
      end
      ST_WRITE: begin
        if (hold_q == '0) begin
          idx_d   = idx_inc;
          state_d = (idx_inc < cnt_q) ? ST_RECV : ST_CHECK;
        end else begin
          hold_d = hold_q - 1'b1;
          we_d   = 1'b1;
          addr_d = addr_q;
        end
      end
      ST_CHECK: begin
        if (take) begin
          if (in_data == chk) begin
            start_d = 1'b1;
            hold_d  = HOLD_LOAD;
            state_d = ST_START;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_START: begin
        if (hold_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hold_d  = hold_q - 1'b1;
          start_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = state_accepts(state_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= 3'd0;
      hold_q  <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = rdy_q;
  assign we1      = we_q;
  assign we2      = we_q;
  assign addr     = addr_q;
  assign start    = start_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_tree_loader.sv
// Self-checking bench for tree_loader: directed frame table, reset during
// a write, and randomized frames checked against a frame-parsing model.
module tb_tree_loader;

  localparam int AW   = 4;
  localparam int R1W  = 34;
  localparam int R2W  = 16;
  localparam int HOLD = 4;
  localparam int MAXN = 2 ** AW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready, we1, we2, start, done, err;
  logic [AW-1:0]  addr;
  logic [R1W-1:0] ram1_data;
  logic [R2W-1:0] ram2_data;

  always #5 clk = ~clk;

  tree_loader #(
    .ADDR_WIDTH(AW), .RAM1_DATA_WIDTH(R1W), .RAM2_DATA_WIDTH(R2W), .WR_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we1(we1), .we2(we2), .addr(addr),
    .ram1_data(ram1_data), .ram2_data(ram2_data),
    .start(start), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic [R1W-1:0] r1;
    logic [R2W-1:0] r2;
    int             len;
    bit             ok;
  } wr_t;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    string        name;
    int           len;
    logic [127:0] b;
    int           nwr;
    int           ndone;
    bit           err;
    logic [33:0]  r1;
    logic [15:0]  r2;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // ---------------- monitor: turns strobe bursts into events ----------------
  wr_t cur;
  wr_t wq[$];
  int  start_len_q[$];
  bit  start_ok_q[$];
  int  done_hi = 0, done_rise = 0, excl_viol = 0;
  bit  prev_we = 0, prev_st = 0, prev_done = 0;
  int  st_len = 0;
  bit  st_ok = 0;

  always @(negedge clk) begin
    if (we1 || we2) begin
      if (!prev_we) begin
        cur.addr = addr; cur.r1 = ram1_data; cur.r2 = ram2_data;
        cur.len = 1; cur.ok = we1 && we2;
      end else begin
        cur.len++;
        if (addr !== cur.addr || ram1_data !== cur.r1 || ram2_data !== cur.r2 || !(we1 && we2))
          cur.ok = 0;
      end
    end else if (prev_we) begin
      wq.push_back(cur);
    end
    prev_we = we1 || we2;
    if (start) begin
      if (!prev_st) begin st_len = 1; st_ok = (addr == '0); end
      else begin st_len++; if (addr != '0) st_ok = 0; end
    end else if (prev_st) begin
      start_len_q.push_back(st_len);
      start_ok_q.push_back(st_ok);
    end
    prev_st = start;
    if (done) done_hi++;
    if (done && !prev_done) done_rise++;
    prev_done = done;
    if ((we1 || we2) && start) excl_viol++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 0;
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference model: walks a byte stream by the frame rules and lists the
  // writes, good-frame completions and the final error flag.
  wr_t exp_q[$];
  bit  model_err = 0;

  task automatic model_run(input byte_q_t s, input bit err_in, output int n_done, output bit err_out);
    int i, n;
    logic [7:0]  sum;
    logic [39:0] coef;
    wr_t e;
    i = 0; n_done = 0; err_out = err_in;
    exp_q.delete();
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin i++; continue; end
      err_out = 0;
      i++;
      if (i >= s.size()) break;
      n = int'(s[i]);
      i++;
      if (n == 0 || n > MAXN) begin err_out = 1; continue; end
      if (i + 7 * n + 1 > s.size()) break;
      sum = 8'h00;
      for (int r = 0; r < n; r++) begin
        coef = {s[i], s[i+1], s[i+2], s[i+3], s[i+4]};
        e.addr = AW'(r);
        e.r1 = coef[33:0];
        e.r2 = {s[i+5], s[i+6]};
        e.len = HOLD;
        e.ok = 1;
        exp_q.push_back(e);
        for (int k = 0; k < 7; k++) sum ^= s[i+k];
        i += 7;
      end
      if (s[i] == sum) n_done++;
      else err_out = 1;
      i++;
    end
  endtask

  // Sends a byte stream and compares the observed events with exp_q and
  // the expected completion count / error flag.
  task automatic run_frame(input string name, input byte_q_t s, input int gap,
                           input int exp_done, input bit exp_err);
    int base_w, base_s, base_d, base_dh, g;
    bit ok;
    wr_t a;
    base_w = wq.size(); base_s = start_len_q.size();
    base_d = done_rise; base_dh = done_hi;
    for (int k = 0; k < s.size(); k++) begin
      send_byte(s[k], ok);
      if (!ok) begin
        compared++; mismatched++;
        $display("FAIL %s_timeout: byte %0d not accepted, required acceptance within 200 cycles", name, k);
        break;
      end
      g = (gap == 2) ? $urandom_range(0, 3) : gap;
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    repeat (3 * HOLD + 8) @(posedge clk);
    #1;
    check({name, "_nwrites"}, wq.size() - base_w, exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      if (base_w + j < wq.size()) begin
        a = wq[base_w + j];
        check($sformatf("%s_w%0d_addr", name, j), a.addr, exp_q[j].addr);
        check($sformatf("%s_w%0d_ram1", name, j), a.r1, exp_q[j].r1);
        check($sformatf("%s_w%0d_ram2", name, j), a.r2, exp_q[j].r2);
        check($sformatf("%s_w%0d_len", name, j), a.len, HOLD);
        check($sformatf("%s_w%0d_stable", name, j), a.ok, 1);
      end
    end
    check({name, "_starts"}, start_len_q.size() - base_s, exp_done);
    for (int j = base_s; j < start_len_q.size(); j++) begin
      check({name, "_start_len"}, start_len_q[j], HOLD);
      check({name, "_start_addr0"}, start_ok_q[j], 1);
    end
    check({name, "_done_pulses"}, done_rise - base_d, exp_done);
    check({name, "_done_cycles"}, done_hi - base_dh, exp_done);
    check({name, "_err"}, err, exp_err);
  endtask

  vec_t vt[7];

  task automatic setv(input int i, input string nm, input int len, input logic [127:0] b,
                      input int nwr, input int nd, input bit e,
                      input logic [33:0] r1, input logic [15:0] r2);
    vt[i].name = nm; vt[i].len = len; vt[i].b = b; vt[i].nwr = nwr;
    vt[i].ndone = nd; vt[i].err = e; vt[i].r1 = r1; vt[i].r2 = r2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    byte_q_t s;
    wr_t     e;
    int      nd, n;
    bit      ee, ok;
    logic [7:0] sum, b;

    setv(0, "one_node",     10, 128'hA5010000000005810286, 1, 1, 0, 34'h5, 16'h8102);
    setv(1, "bad_chk",      10, 128'hA5010000000005810279, 1, 0, 1, 34'h5, 16'h8102);
    setv(2, "recover",      10, 128'hA5010000000123456700, 1, 1, 0, 34'h123, 16'h4567);
    setv(3, "count_zero",    2, 128'hA500,                 0, 0, 1, 34'h0, 16'h0);
    setv(4, "count_17",      2, 128'hA511,                 0, 0, 1, 34'h0, 16'h0);
    setv(5, "junk_in_err",  12, 128'h00FFA501FFFFFFFFFFFFFFFF, 1, 1, 0, 34'h3FFFFFFFF, 16'hFFFF);
    setv(6, "junk_in_idle", 12, 128'hFF00A50100000000000000_00, 1, 1, 0, 34'h0, 16'h0);

    // reset values while rst_n is held low
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_strobes", {we1, we2, start, done, err}, 5'b0);
    check("rst_addr", addr, 0);
    check("rst_ram1", ram1_data, 0);
    check("rst_ram2", ram2_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // directed table
    for (int v = 0; v < 7; v++) begin
      s = {};
      for (int k = 0; k < vt[v].len; k++) begin
        b = vt[v].b[8 * (vt[v].len - 1 - k) +: 8];
        s.push_back(b);
      end
      exp_q.delete();
      if (vt[v].nwr == 1) begin
        e.addr = '0; e.r1 = vt[v].r1; e.r2 = vt[v].r2; e.len = HOLD; e.ok = 1;
        exp_q.push_back(e);
      end
      run_frame(vt[v].name, s, 0, vt[v].ndone, vt[v].err);
    end
    model_err = 0;

    // reset asserted during the second WRITE cycle
    s = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
    for (int k = 0; k < s.size(); k++) begin
      send_byte(s[k], ok);
      if (!ok) begin
        compared++; mismatched++;
        $display("FAIL midrst_timeout: byte %0d not accepted, required acceptance", k);
        break;
      end
    end
    check("midrst_we_before", we1, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {we1, we2, start, done, err}, 5'b0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_addr", addr, 0);
    check("midrst_ram1", ram1_data, 0);
    check("midrst_ram2", ram2_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", in_ready, 1);
    model_err = 0;

    // randomized frames against the model
    for (int it = 0; it < 12; it++) begin
      s = {};
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          s.push_back(b);
        end
      end
      s.push_back(8'hA5);
      if (it > 2 && $urandom_range(0, 5) == 0) begin
        b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXN + 1, 255));
        s.push_back(b);
      end else begin
        n = (it == 0) ? MAXN : (it == 1) ? 3 : $urandom_range(1, MAXN);
        s.push_back(8'(n));
        sum = 8'h00;
        repeat (7 * n) begin
          b = 8'($urandom);
          s.push_back(b);
          sum ^= b;
        end
        if (it > 1 && $urandom_range(0, 3) == 0) sum ^= 8'($urandom_range(1, 255));
        s.push_back(sum);
      end
      model_run(s, model_err, nd, ee);
      run_frame($sformatf("rand%0d", it), s, (it == 1) ? 1 : (it % 3), nd, ee);
      model_err = ee;
    end

    check("strobe_exclusive", excl_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
